// File: rtl/biquad_pkg.sv
// Shared types for the biquad bank sequencer: coefficient layout, FSM states,
// per-band coefficient set and per-band filter history.
package biquad_pkg;

  localparam int COEFFS_PER_BAND = 10;

  typedef enum logic [3:0] {
    A1_0 = 4'd0,
    A2_0 = 4'd1,
    B0_0 = 4'd2,
    B1_0 = 4'd3,
    B2_0 = 4'd4,
    A1_1 = 4'd5,
    A2_1 = 4'd6,
    B0_1 = 4'd7,
    B1_1 = 4'd8,
    B2_1 = 4'd9
  } coeff_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  typedef struct packed {
    logic signed [31:0] a1_0;
    logic signed [31:0] a2_0;
    logic signed [31:0] b0_0;
    logic signed [31:0] b1_0;
    logic signed [31:0] b2_0;
    logic signed [31:0] a1_1;
    logic signed [31:0] a2_1;
    logic signed [31:0] b0_1;
    logic signed [31:0] b1_1;
    logic signed [31:0] b2_1;
  } coeff_set_t;

  typedef struct packed {
    logic signed [31:0] i_n1;
    logic signed [31:0] i_n2;
    logic signed [31:0] y_n1;
    logic signed [31:0] y_n2;
  } hist_t;

endpackage

// File: rtl/double_biquad.sv
// Two cascaded direct-form-I biquads, purely combinational. Each product is
// 64-bit, shifted by SHIFT, and the sums wrap at 32 bits (no saturation).
module double_biquad import biquad_pkg::*; #(
  parameter int SHIFT = 20
) (
  input  logic signed [31:0] x_n,
  input  logic signed [31:0] x_n1,
  input  logic signed [31:0] x_n2,
  input  logic signed [31:0] i_n1,
  input  logic signed [31:0] i_n2,
  input  logic signed [31:0] y_n1,
  input  logic signed [31:0] y_n2,
  input  coeff_set_t         coeffs,
  output logic signed [31:0] i_n,
  output logic signed [31:0] y_n
);

  // Truncating each shifted product before summing is equivalent modulo 2^32
  function automatic logic signed [31:0] mac_term(input logic signed [31:0] c,
                                                   input logic signed [31:0] v);
    return 32'((64'(c) * 64'(v)) >>> SHIFT);
  endfunction

  assign i_n = mac_term(coeffs.b0_0, x_n) + mac_term(coeffs.b1_0, x_n1)
             + mac_term(coeffs.b2_0, x_n2) - mac_term(coeffs.a1_0, i_n1)
             - mac_term(coeffs.a2_0, i_n2);

  assign y_n = mac_term(coeffs.b0_1, i_n) + mac_term(coeffs.b1_1, i_n1)
             + mac_term(coeffs.b2_1, i_n2) - mac_term(coeffs.a1_1, y_n1)
             - mac_term(coeffs.a2_1, y_n2);

endmodule

// File: rtl/biquad_bank_sequencer.sv
// Steps each input sample through NUM_BANDS double-biquad bands, one band per
// FETCH/COMPUTE/WRITE slot, using a single shared double_biquad datapath.
module biquad_bank_sequencer import biquad_pkg::*; #(
  parameter  int NUM_BANDS = 16,
  parameter  int SHIFT     = 20,
  localparam int AW        = $clog2(10 * NUM_BANDS),
  localparam int BW        = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic signed [31:0]   sample_in,
  input  logic                 sample_valid_in,
  input  logic                 coeff_we_in,
  input  logic [AW-1:0]        coeff_addr_in,
  input  logic signed [31:0]   coeff_data_in,
  input  logic                 clear_state_in,
  output logic signed [31:0]   band_out,
  output logic [BW-1:0]        band_idx_out,
  output logic                 band_valid_out,
  output logic                 frame_done_out,
  output logic                 busy_out,
  output logic                 overrun_out
);

  localparam int COEFF_WORDS = COEFFS_PER_BAND * NUM_BANDS;

  state_t             state_r, state_nxt_s;
  logic [BW-1:0]      band_r;
  logic               last_band_s;
  logic [AW-1:0]      cbase_s;
  logic signed [31:0] x_n_r, x_n1_r, x_n2_r;
  logic signed [31:0] coeff_mem_r [COEFF_WORDS];
  hist_t              hist_r [NUM_BANDS];
  coeff_set_t         coeff_op_r;
  hist_t              hist_op_r;
  logic signed [31:0] i_n_s, y_n_s, i_n_r, y_n_r;
  logic               band_valid_r, frame_done_r, busy_r, overrun_r;

  assign last_band_s = (band_r == BW'(NUM_BANDS - 1));
  assign cbase_s     = AW'(band_r) * AW'(COEFFS_PER_BAND);

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst_in) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sample_valid_in) state_nxt_s = ST_FETCH;
        else                 state_nxt_s = ST_IDLE;
      end
      ST_FETCH:   state_nxt_s = ST_COMPUTE;
      ST_COMPUTE: state_nxt_s = ST_WRITE;
      ST_WRITE: begin
        if (last_band_s) state_nxt_s = ST_DONE;
        else             state_nxt_s = ST_FETCH;
      end
      ST_DONE:    state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Coefficient store; writes accepted in any state, out-of-range addresses dropped
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int w = 0; w < COEFF_WORDS; w++) coeff_mem_r[w] <= 32'sd0;
    end else if (coeff_we_in && (coeff_addr_in < AW'(COEFF_WORDS))) begin
      coeff_mem_r[coeff_addr_in] <= coeff_data_in;
    end
  end

  // Datapath sequencing, history stores and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      band_r       <= '0;
      x_n_r        <= 32'sd0;
      x_n1_r       <= 32'sd0;
      x_n2_r       <= 32'sd0;
      coeff_op_r   <= '0;
      hist_op_r    <= '0;
      i_n_r        <= 32'sd0;
      y_n_r        <= 32'sd0;
      band_valid_r <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) hist_r[b] <= '0;
    end else begin
      band_valid_r <= (state_r == ST_COMPUTE);
      frame_done_r <= (state_r == ST_WRITE) && last_band_s;
      if (sample_valid_in && (state_r != ST_IDLE)) overrun_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          // Clear and accept may coincide: the new frame then sees zeroed history
          if (clear_state_in) begin
            x_n1_r <= 32'sd0;
            x_n2_r <= 32'sd0;
            for (int b = 0; b < NUM_BANDS; b++) hist_r[b] <= '0;
          end
          if (sample_valid_in) begin
            x_n_r  <= sample_in;
            band_r <= '0;
            busy_r <= 1'b1;
          end
        end
        ST_FETCH: begin
          coeff_op_r.a1_0 <= coeff_mem_r[cbase_s + AW'(A1_0)];
          coeff_op_r.a2_0 <= coeff_mem_r[cbase_s + AW'(A2_0)];
          coeff_op_r.b0_0 <= coeff_mem_r[cbase_s + AW'(B0_0)];
          coeff_op_r.b1_0 <= coeff_mem_r[cbase_s + AW'(B1_0)];
          coeff_op_r.b2_0 <= coeff_mem_r[cbase_s + AW'(B2_0)];
          coeff_op_r.a1_1 <= coeff_mem_r[cbase_s + AW'(A1_1)];
          coeff_op_r.a2_1 <= coeff_mem_r[cbase_s + AW'(A2_1)];
          coeff_op_r.b0_1 <= coeff_mem_r[cbase_s + AW'(B0_1)];
          coeff_op_r.b1_1 <= coeff_mem_r[cbase_s + AW'(B1_1)];
          coeff_op_r.b2_1 <= coeff_mem_r[cbase_s + AW'(B2_1)];
          hist_op_r       <= hist_r[band_r];
        end
        ST_COMPUTE: begin
          i_n_r <= i_n_s;
          y_n_r <= y_n_s;
        end
        ST_WRITE: begin
          hist_r[band_r] <= '{i_n1: i_n_r, i_n2: hist_op_r.i_n1,
                             y_n1: y_n_r, y_n2: hist_op_r.y_n1};
          if (!last_band_s) band_r <= band_r + BW'(1);
        end
        ST_DONE: begin
          x_n2_r <= x_n1_r;
          x_n1_r <= x_n_r;
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  double_biquad #(.SHIFT(SHIFT)) u_double_biquad (
    .x_n    (x_n_r),
    .x_n1   (x_n1_r),
    .x_n2   (x_n2_r),
    .i_n1   (hist_op_r.i_n1),
    .i_n2   (hist_op_r.i_n2),
    .y_n1   (hist_op_r.y_n1),
    .y_n2   (hist_op_r.y_n2),
    .coeffs (coeff_op_r),
    .i_n    (i_n_s),
    .y_n    (y_n_s)
  );

  assign band_out       = y_n_r;
  assign band_idx_out   = band_r;
  assign band_valid_out = band_valid_r;
  assign frame_done_out = frame_done_r;
  assign busy_out       = busy_r;
  assign overrun_out    = overrun_r;

endmodule
